// File: rtl/pad_bus_bridge.sv
// pad_bus_bridge: synchronises the async nibble-wide pad register bus and bridges it to a word-wide core register port.
module pad_bus_bridge #(
  parameter int ADDR_W      = 3,
  parameter int NIB_W       = 4,
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RD_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [NIB_W-1:0]  data_in,
  output logic [NIB_W-1:0]  data_out,
  output logic              core_wr_en,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [WORD_W-1:0] core_wr_data,
  output logic              core_rd_en,
  output logic [ADDR_W-1:0] core_rd_addr,
  input  logic [WORD_W-1:0] core_rd_data,
  input  logic              core_rd_valid,
  output logic              busy,
  output logic              proto_err
);
  localparam int NNIB = WORD_W / NIB_W;
  localparam int CW   = NNIB > 1 ? $clog2(NNIB) : 1;
  localparam int TW   = $clog2(RD_TIMEOUT + 1);
  localparam int SW   = 2 + ADDR_W + NIB_W;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic [1:0]                     prev_q, prev_d;
  logic [ADDR_W-1:0]              wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [WORD_W-1:0]              wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
  logic [CW-1:0]                  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [TW-1:0]                  tmo_q, tmo_d;
  logic [NIB_W-1:0]               data_out_q, data_out_d;
  logic                           wr_en_q, wr_en_d, rd_en_q, rd_en_d, err_q, err_d;
  logic                           s_rd, s_wr, rd_edge, wr_edge, wr_new, wr_done;
  logic [ADDR_W-1:0]              s_addr;
  logic [NIB_W-1:0]               s_din;
  logic [CW-1:0]                  wr_base_cnt;
  logic [WORD_W-1:0]              wr_base, rd_shift;
  assign {s_rd, s_wr, s_addr, s_din} = sync_q[SYNC_STAGES-1];
  assign rd_edge      = s_rd & ~prev_q[1];
  assign wr_edge      = s_wr & ~prev_q[0];
  assign data_out     = data_out_q;
  assign core_wr_en   = wr_en_q;
  assign core_wr_addr = wr_addr_q;
  assign core_wr_data = wr_buf_q;
  assign core_rd_en   = rd_en_q;
  assign core_rd_addr = rd_addr_q;
  assign busy         = state_q == WAIT;
  assign proto_err    = err_q;
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], read, write, address, data_in};
    prev_d      = {s_rd, s_wr};
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    wr_buf_d    = wr_buf_q;
    wr_cnt_d    = wr_cnt_q;
    rd_addr_d   = rd_addr_q;
    rd_buf_d    = rd_buf_q;
    rd_cnt_d    = rd_cnt_q;
    tmo_d       = tmo_q;
    data_out_d  = data_out_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    err_d       = err_q;
    wr_new      = wr_cnt_q == '0 || s_addr != wr_addr_q;
    wr_base     = wr_new ? '0 : wr_buf_q;
    wr_base_cnt = wr_new ? '0 : wr_cnt_q;
    wr_done     = wr_base_cnt == CW'(NNIB - 1);
    rd_shift    = rd_buf_q >> NIB_W;
    if (wr_edge) begin
      err_d     = err_q | (wr_cnt_q != '0 && s_addr != wr_addr_q);
      wr_addr_d = s_addr;
      wr_buf_d  = (wr_base >> NIB_W) | (WORD_W'(s_din) << (WORD_W - NIB_W));
      wr_cnt_d  = wr_done ? '0 : wr_base_cnt + CW'(1);
      wr_en_d   = wr_done;
    end
    if (rd_edge && wr_edge)
      err_d = 1'b1;
    if (state_q == IDLE) begin
      if (rd_edge && !wr_edge) begin
        if (rd_cnt_q == '0 || s_addr != rd_addr_q) begin
          rd_addr_d = s_addr;
          rd_en_d   = 1'b1;
          tmo_d     = '0;
          state_d   = WAIT;
        end else begin
          rd_buf_d   = rd_shift;
          data_out_d = rd_shift[NIB_W-1:0];
          rd_cnt_d   = rd_cnt_q == CW'(NNIB - 1) ? '0 : rd_cnt_q + CW'(1);
        end
      end
    end else begin
      tmo_d = tmo_q + TW'(1);
      if (rd_edge)
        err_d = 1'b1;
      // valid coincident with the request pulse is stale and must not complete the fetch
      if (core_rd_valid && !rd_en_q) begin
        rd_buf_d   = core_rd_data;
        data_out_d = core_rd_data[NIB_W-1:0];
        rd_cnt_d   = CW'(NNIB > 1 ? 1 : 0);
        state_d    = IDLE;
      end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
        rd_buf_d   = '1;
        data_out_d = '1;
        rd_cnt_d   = CW'(1);
        err_d      = 1'b1;
        state_d    = IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sync_q     <= '0;
      prev_q     <= '0;
      wr_addr_q  <= '0;
      wr_buf_q   <= '0;
      wr_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_buf_q   <= '0;
      rd_cnt_q   <= '0;
      tmo_q      <= '0;
      data_out_q <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      wr_addr_q  <= wr_addr_d;
      wr_buf_q   <= wr_buf_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_buf_q   <= rd_buf_d;
      rd_cnt_q   <= rd_cnt_d;
      tmo_q      <= tmo_d;
      data_out_q <= data_out_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_pad_bus_bridge.sv
// tb_pad_bus_bridge: scoreboard bench for pad_bus_bridge with a delayed-response core model.
module tb_pad_bus_bridge;
  logic        clk = 0, rst_n = 0, read = 0, write = 0;
  logic [2:0]  address = 0;
  logic [3:0]  data_in = 0;
  logic [3:0]  data_out;
  logic        core_wr_en, core_rd_en, busy, proto_err;
  logic [2:0]  core_wr_addr, core_rd_addr;
  logic [15:0] core_wr_data;
  logic [15:0] core_rd_data = 0;
  logic        core_rd_valid = 0;
  int          checks = 0, errors = 0, wr_en_cnt = 0, rd_en_cnt = 0, busy_cnt = 0;
  logic [18:0] wq[$];
  logic [3:0]  rq[$];
  logic [18:0] wexp;
  bit          resp_en = 1;
  int          resp_delay = 3;
  logic [15:0] resp_data = 16'hBEEF;
  always #5 clk = ~clk;
  pad_bus_bridge dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .address(address), .data_in(data_in),
    .data_out(data_out), .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
    .core_rd_en(core_rd_en), .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data),
    .core_rd_valid(core_rd_valid), .busy(busy), .proto_err(proto_err)
  );
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (core_rd_en) rd_en_cnt++;
      if (core_wr_en) begin
        wr_en_cnt++;
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected: got addr=%0d data=%h, required no write", core_wr_addr, core_wr_data);
        end else begin
          wexp = wq.pop_front();
          if ({core_wr_addr, core_wr_data} !== wexp) begin
            errors++;
            $display("FAIL wr_word: got addr=%0d data=%h, required addr=%0d data=%h",
                     core_wr_addr, core_wr_data, wexp[18:16], wexp[15:0]);
          end
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (rst_n && core_rd_en && resp_en) begin
      repeat (resp_delay) @(posedge clk);
      #1 core_rd_data = resp_data;
      core_rd_valid = 1;
      @(posedge clk);
      #1 core_rd_valid = 0;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
  task automatic do_reset();
    rst_n = 0; read = 0; write = 0; address = 0; data_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (2) @(posedge clk);
  endtask
  task automatic pad_write(input logic [2:0] a, input logic [3:0] d);
    address = a; data_in = d;
    @(posedge clk); #1 write = 1;
    repeat (4) @(posedge clk); #1 write = 0;
    repeat (4) @(posedge clk); #1;
  endtask
  task automatic pad_read(input string name, input logic [2:0] a, input logic [3:0] exp);
    int n;
    logic [3:0] e;
    rq.push_back(exp);
    address = a;
    @(posedge clk); #1 read = 1;
    repeat (4) @(posedge clk); #1 read = 0;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1 n++; end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL %s_busy_bound: got busy=%b after 40 cycles, required 0", name, busy); end
    repeat (3) @(posedge clk); #1;
    e = rq.pop_front();
    checks++;
    if (data_out !== e) begin errors++; $display("FAIL %s: got data_out=%h, required %h", name, data_out, e); end
  endtask
  task automatic test_reset();
    do_reset();
    checks++;
    if ({data_out, core_wr_en, core_rd_en, busy, proto_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs: got data_out=%h wr_en=%b rd_en=%b busy=%b err=%b, required all 0",
               data_out, core_wr_en, core_rd_en, busy, proto_err);
    end
    checks++;
    if ({core_wr_addr, core_wr_data, core_rd_addr} !== 22'h0) begin
      errors++;
      $display("FAIL reset_core: got wr_addr=%0d wr_data=%h rd_addr=%0d, required 0", core_wr_addr, core_wr_data, core_rd_addr);
    end
  endtask
  task automatic test_write_word();
    int c0 = wr_en_cnt;
    wq.push_back({3'd5, 16'h4321});
    pad_write(5, 1); pad_write(5, 2); pad_write(5, 3);
    checks++;
    if (wr_en_cnt !== c0) begin errors++; $display("FAIL wr_early: got %0d pulses, required 0", wr_en_cnt - c0); end
    pad_write(5, 4);
    checks++;
    if (wr_en_cnt !== c0 + 1) begin errors++; $display("FAIL wr_pulses: got %0d, required 1", wr_en_cnt - c0); end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL wr_err: got proto_err=%b, required 0", proto_err); end
  endtask
  task automatic test_read_seq();
    int c0 = rd_en_cnt;
    resp_data = 16'hBEEF; resp_delay = 3;
    pad_read("rd_n0", 2, 4'hF);
    pad_read("rd_n1", 2, 4'hE);
    pad_read("rd_n2", 2, 4'hE);
    pad_read("rd_n3", 2, 4'hB);
    checks++;
    if (rd_en_cnt !== c0 + 1) begin errors++; $display("FAIL rd_single_fetch: got %0d, required 1", rd_en_cnt - c0); end
    checks++;
    if (core_rd_addr !== 3'd2) begin errors++; $display("FAIL rd_addr: got %0d, required 2", core_rd_addr); end
    resp_data = 16'h1234;
    pad_read("rd_refetch", 2, 4'h4);
    checks++;
    if (rd_en_cnt !== c0 + 2) begin errors++; $display("FAIL rd_refetch_en: got %0d, required 2", rd_en_cnt - c0); end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL rd_err: got proto_err=%b, required 0", proto_err); end
  endtask
  task automatic test_addr_change();
    int c0;
    do_reset();
    c0 = wr_en_cnt;
    pad_write(1, 4'hA); pad_write(1, 4'hB);
    wq.push_back({3'd6, 16'hEDC9});
    pad_write(6, 4'h9);
    checks++;
    if (wr_en_cnt !== c0 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL addr_change: got pulses=%0d err=%b, required 0 and 1", wr_en_cnt - c0, proto_err);
    end
    pad_write(6, 4'hC); pad_write(6, 4'hD); pad_write(6, 4'hE);
    checks++;
    if (wr_en_cnt !== c0 + 1) begin errors++; $display("FAIL addr_change_word: got %0d pulses, required 1", wr_en_cnt - c0); end
  endtask
  task automatic test_timeout();
    do_reset();
    resp_en = 0;
    busy_cnt = 0;
    pad_read("tmo_data", 3, 4'hF);
    checks++;
    if (busy_cnt !== 15) begin errors++; $display("FAIL tmo_busy_len: got %0d cycles, required 15", busy_cnt); end
    checks++;
    if ({proto_err, busy} !== 2'b10) begin errors++; $display("FAIL tmo_flags: got err=%b busy=%b, required 1 0", proto_err, busy); end
    resp_en = 1;
    pad_read("tmo_next", 3, 4'hF);
  endtask
  task automatic test_simultaneous();
    int r0, w0;
    do_reset();
    r0 = rd_en_cnt; w0 = wr_en_cnt;
    wq.push_back({3'd4, 16'h3217});
    address = 4; data_in = 7;
    @(posedge clk); #1 read = 1; write = 1;
    repeat (4) @(posedge clk); #1 read = 0; write = 0;
    repeat (6) @(posedge clk); #1;
    checks++;
    if (rd_en_cnt !== r0 || busy !== 1'b0) begin errors++; $display("FAIL sim_rd_drop: got rd_en=%0d busy=%b, required 0 0", rd_en_cnt - r0, busy); end
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL sim_err: got %b, required 1", proto_err); end
    pad_write(4, 1); pad_write(4, 2); pad_write(4, 3);
    checks++;
    if (wr_en_cnt !== w0 + 1) begin errors++; $display("FAIL sim_wr_word: got %0d pulses, required 1", wr_en_cnt - w0); end
  endtask
  task automatic test_reset_mid_wait();
    int n;
    do_reset();
    resp_data = 16'h00A5; resp_delay = 3;
    pad_read("mid_pre", 2, 4'h5);
    resp_data = 16'h0077; resp_delay = 10;
    address = 3;
    @(posedge clk); #1 read = 1;
    n = 0;
    while (!busy && n < 20) begin @(posedge clk); #1 n++; end
    checks++;
    if (!busy) begin errors++; $display("FAIL mid_busy: got busy=%b, required 1", busy); end
    @(posedge clk); #2 rst_n = 0; read = 0;
    #1;
    checks++;
    if ({data_out, busy, core_rd_en, proto_err, core_rd_addr} !== 10'h0) begin
      errors++;
      $display("FAIL mid_reset_outs: got data_out=%h busy=%b rd_en=%b err=%b rd_addr=%0d, required all 0",
               data_out, busy, core_rd_en, proto_err, core_rd_addr);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    repeat (15) @(posedge clk); #1;
    checks++;
    if ({data_out, busy} !== 5'h0) begin errors++; $display("FAIL mid_late_valid: got data_out=%h busy=%b, required 0 0", data_out, busy); end
  endtask
  initial begin
    test_reset();
    test_write_word();
    test_read_seq();
    test_addr_change();
    test_timeout();
    test_simultaneous();
    test_reset_mid_wait();
    repeat (4) @(posedge clk); #1;
    checks++;
    if (wq.size() != 0) begin errors++; $display("FAIL wr_missing: got %0d outstanding writes, required 0", wq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
